// File: rtl/inst_buf_if.sv
// Fetch-to-decode handshake bundle for inst_buf: IFU push side, IDU pop side,
// flush and occupancy. slave = buffer side, master = driver side.
interface inst_buf_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                    ifu_valid_i;
  logic [ADDR_WIDTH-1:0]   ifu_pc_i;
  logic [INST_WIDTH-1:0]   ifu_instr_i;
  logic                    ifu_ready_o;
  logic                    idu_valid_o;
  logic [ADDR_WIDTH-1:0]   idu_pc_o;
  logic [INST_WIDTH-1:0]   idu_instr_o;
  logic                    idu_ready_i;
  logic                    flush_i;
  logic [$clog2(DEPTH):0]  count_o;

  modport slave (
    input  ifu_valid_i, ifu_pc_i, ifu_instr_i, idu_ready_i, flush_i,
    output ifu_ready_o, idu_valid_o, idu_pc_o, idu_instr_o, count_o
  );

  modport master (
    output ifu_valid_i, ifu_pc_i, ifu_instr_i, idu_ready_i, flush_i,
    input  ifu_ready_o, idu_valid_o, idu_pc_o, idu_instr_o, count_o
  );
endinterface

// File: rtl/inst_buf.sv
// Instruction buffer: circular FIFO of {pc, instr} between fetch and decode.
// Optional macro INST_BUF_BYPASS_EN forwards the fetch pair straight to decode when empty.
module inst_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  inst_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_ent, head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop, wr_en, rd_en, out_vld;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign in_ent = {bus.ifu_pc_i, bus.ifu_instr_i};

`ifdef INST_BUF_BYPASS_EN
  // Bypass is masked in reset so the outputs stay quiet while rst_n is low.
  logic byp;
  assign byp     = empty & rst_n;
  assign out_vld = !bus.flush_i & (byp ? bus.ifu_valid_i : !empty);
  assign head    = byp ? in_ent : mem[rd_ptr];
  assign wr_en   = push & !(byp & bus.idu_ready_i);
  assign rd_en   = pop & !empty;
`else
  assign out_vld = !bus.flush_i & !empty;
  assign head    = mem[rd_ptr];
  assign wr_en   = push;
  assign rd_en   = pop;
`endif

  assign push = bus.ifu_valid_i & !full & !bus.flush_i;
  assign pop  = out_vld & bus.idu_ready_i;

  assign bus.ifu_ready_o = !full;
  assign bus.idu_valid_o = out_vld;
  assign bus.idu_pc_o    = out_vld ? head.pc    : '0;
  assign bus.idu_instr_o = out_vld ? head.instr : '0;
  assign bus.count_o     = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never observed before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_ent;
  end
endmodule

// File: tb/tb_inst_buf.sv
// Self-checking bench for inst_buf: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_inst_buf;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef INST_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;
  ent_t q[$];

  inst_buf_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) bif();

  inst_buf #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: decoder sees queue head, or the live fetch pair when bypassing an empty queue.
  function automatic bit m_valid();
    if (bif.flush_i) return 1'b0;
    if (q.size() == 0) return BYP && bif.ifu_valid_i;
    return 1'b1;
  endfunction

  function automatic logic [AW-1:0] m_pc();
    if (!m_valid()) return '0;
    return (q.size() != 0) ? q[0].pc : bif.ifu_pc_i;
  endfunction

  function automatic logic [IW-1:0] m_instr();
    if (!m_valid()) return '0;
    return (q.size() != 0) ? q[0].instr : bif.ifu_instr_i;
  endfunction

  task automatic drive(input bit v, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                       input bit rdy, input bit fl);
    bif.ifu_valid_i = v;
    bif.ifu_pc_i    = pc;
    bif.ifu_instr_i = ins;
    bif.idu_ready_i = rdy;
    bif.flush_i     = fl;
    #1;
  endtask

  task automatic tick();
    bit   f, push, pop;
    ent_t e;
    f      = bif.flush_i;
    push   = bif.ifu_valid_i && (q.size() < DEPTH) && !f;
    pop    = m_valid() && bif.idu_ready_i;
    e.pc    = bif.ifu_pc_i;
    e.instr = bif.ifu_instr_i;
    @(posedge clk);
    if (f) q.delete();
    else if (!(q.size() == 0 && pop)) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, 0);
    n_checks++; if (bif.idu_valid_o !== 1'b0) begin n_errs++; $display("FAIL rst_valid got %b want 0", bif.idu_valid_o); end
    n_checks++; if (bif.idu_pc_o !== '0) begin n_errs++; $display("FAIL rst_pc got %h want 0", bif.idu_pc_o); end
    n_checks++; if (bif.idu_instr_o !== '0) begin n_errs++; $display("FAIL rst_instr got %h want 0", bif.idu_instr_o); end
    n_checks++; if (bif.ifu_ready_o !== 1'b1) begin n_errs++; $display("FAIL rst_ready got %b want 1", bif.ifu_ready_o); end
    n_checks++; if (bif.count_o !== CW'(0)) begin n_errs++; $display("FAIL rst_count got %0d want 0", bif.count_o); end
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({bif.idu_valid_o, bif.ifu_ready_o, bif.count_o} !== {1'b0, 1'b1, CW'(0)}) begin
      n_errs++; $display("FAIL post_rst got v=%b r=%b c=%0d want v=0 r=1 c=0", bif.idu_valid_o, bif.ifu_ready_o, bif.count_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0000 + 32'(4 * i), $urandom, 0, 0);
      n_checks++; if (bif.ifu_ready_o !== 1'b1) begin n_errs++; $display("FAIL fill_ready[%0d] got %b want 1", i, bif.ifu_ready_o); end
      tick();
    end
    drive(1, 32'h8000_0010, $urandom, 0, 0);
    n_checks++; if (bif.count_o !== CW'(4)) begin n_errs++; $display("FAIL full_count got %0d want 4", bif.count_o); end
    n_checks++; if (bif.ifu_ready_o !== 1'b0) begin n_errs++; $display("FAIL full_ready got %b want 0", bif.ifu_ready_o); end
    n_checks++; if (bif.idu_pc_o !== 32'h8000_0000) begin n_errs++; $display("FAIL full_head got %h want 80000000", bif.idu_pc_o); end
    tick();
    n_checks++; if (bif.count_o !== CW'(4)) begin n_errs++; $display("FAIL fifth_push got count %0d want 4", bif.count_o); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 1, 0);
      n_checks++; if (bif.idu_valid_o !== 1'b1 || bif.idu_pc_o !== 32'h8000_0000 + 32'(4 * i)) begin
        n_errs++; $display("FAIL drain_pc[%0d] got v=%b %h want v=1 %h", i, bif.idu_valid_o, bif.idu_pc_o, 32'h8000_0000 + 32'(4 * i));
      end
      n_checks++; if (bif.idu_instr_o !== m_instr()) begin n_errs++; $display("FAIL drain_instr[%0d] got %h want %h", i, bif.idu_instr_o, m_instr()); end
      tick();
    end
    drive(0, '0, '0, 0, 0);
    n_checks++; if (bif.idu_valid_o !== 1'b0 || bif.count_o !== CW'(0)) begin
      n_errs++; $display("FAIL drain_end got v=%b c=%0d want v=0 c=0", bif.idu_valid_o, bif.count_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h100 + 32'(4 * i), $urandom, 0, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h108 + 32'(4 * i), $urandom, 1, 0);
      n_checks++; if (bif.count_o !== CW'(2) || bif.idu_pc_o !== 32'h100 + 32'(4 * i)) begin
        n_errs++; $display("FAIL stream[%0d] got c=%0d pc=%h want c=2 pc=%h", i, bif.count_o, bif.idu_pc_o, 32'h100 + 32'(4 * i));
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, '0, 1, 0);
      n_checks++; if (bif.idu_pc_o !== 32'h128 + 32'(4 * i)) begin
        n_errs++; $display("FAIL stream_tail[%0d] got %h want %h", i, bif.idu_pc_o, 32'h128 + 32'(4 * i));
      end
      tick();
    end
    n_checks++; if (bif.count_o !== CW'(0)) begin n_errs++; $display("FAIL stream_end got count %0d want 0", bif.count_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), $urandom, 0, 0);
      tick();
    end
    drive(1, 32'hDEAD_0000, $urandom, 1, 1);
    n_checks++; if (bif.idu_valid_o !== 1'b0) begin n_errs++; $display("FAIL flush_cycle_valid got %b want 0", bif.idu_valid_o); end
    tick();
    drive(0, '0, '0, 1, 0);
    n_checks++; if (bif.count_o !== CW'(0) || bif.idu_valid_o !== 1'b0) begin
      n_errs++; $display("FAIL after_flush got c=%0d v=%b want c=0 v=0", bif.count_o, bif.idu_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bif.idu_valid_o !== 1'b0) begin n_errs++; $display("FAIL flush_leak[%0d] got pc %h", i, bif.idu_pc_o); end
    end
  endtask

  task automatic test_bypass();
    logic [IW-1:0] ins;
    ins = $urandom;
    drive(1, 32'h8000_0010, ins, 1, 0);
    if (BYP) begin
      n_checks++; if (bif.idu_valid_o !== 1'b1 || bif.idu_pc_o !== 32'h8000_0010 || bif.idu_instr_o !== ins) begin
        n_errs++; $display("FAIL bypass_same got v=%b %h want v=1 80000010", bif.idu_valid_o, bif.idu_pc_o);
      end
      tick();
      drive(0, '0, '0, 1, 0);
      n_checks++; if (bif.count_o !== CW'(0) || bif.idu_valid_o !== 1'b0) begin
        n_errs++; $display("FAIL bypass_stored got c=%0d v=%b want c=0 v=0", bif.count_o, bif.idu_valid_o);
      end
    end else begin
      n_checks++; if (bif.idu_valid_o !== 1'b0) begin n_errs++; $display("FAIL nobyp_same got v=%b want 0", bif.idu_valid_o); end
      tick();
      drive(0, '0, '0, 1, 0);
      n_checks++; if (bif.idu_valid_o !== 1'b1 || bif.idu_pc_o !== 32'h8000_0010 || bif.count_o !== CW'(1)) begin
        n_errs++; $display("FAIL nobyp_next got v=%b %h c=%0d want v=1 80000010 c=1", bif.idu_valid_o, bif.idu_pc_o, bif.count_o);
      end
      tick();
      n_checks++; if (bif.count_o !== CW'(0)) begin n_errs++; $display("FAIL nobyp_pop got c=%0d want 0", bif.count_o); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h400 + 32'(4 * i), $urandom, 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    n_checks++; if ({bif.idu_valid_o, bif.ifu_ready_o, bif.count_o, bif.idu_pc_o} !== {1'b0, 1'b1, CW'(0), 32'h0}) begin
      n_errs++; $display("FAIL async_rst got v=%b r=%b c=%0d pc=%h want v=0 r=1 c=0 pc=0",
                         bif.idu_valid_o, bif.ifu_ready_o, bif.count_o, bif.idu_pc_o);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 32'h200, $urandom, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    n_checks++; if (bif.count_o !== CW'(1) || bif.idu_pc_o !== 32'h200) begin
      n_errs++; $display("FAIL post_async got c=%0d pc=%h want c=1 pc=200", bif.count_o, bif.idu_pc_o);
    end
    drive(0, '0, '0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    logic [2+CW+AW+IW-1:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0, ($urandom % 25) == 0);
      got = {bif.idu_valid_o, bif.ifu_ready_o, bif.count_o, bif.idu_pc_o, bif.idu_instr_o};
      exp = {m_valid(), (q.size() < DEPTH), CW'(q.size()), m_pc(), m_instr()};
      n_checks++; if (got !== exp) begin
        n_errs++; $display("FAIL random[%0d] got %h want %h", i, got, exp);
      end
      tick();
    end
    drive(0, '0, '0, 0, 1);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
